// File: rtl/pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage
// Description : Two-entry (main + skid) pipeline register with registered
//               in_ready, flush, and a saturating backpressure counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage #(
    parameter int IW = 32,
    parameter int N  = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [N-1:0]  in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [N-1:0]  out_pc,
    input  logic          flush,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CW-1:0] c_STALL_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] c_STALL_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [IW-1:0] main_instr_q, main_instr_d;
    logic [N-1:0]  main_pc_q, main_pc_d;
    logic [IW-1:0] skid_instr_q, skid_instr_d;
    logic [N-1:0]  skid_pc_q, skid_pc_d;
    logic          in_ready_q, in_ready_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;

    assign w_out_valid = (state_q != ST_EMPTY);
    assign w_in_fire   = in_valid & in_ready_q;
    assign w_out_fire  = w_out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        case (state_q)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end else if (w_in_fire) begin
                    skid_instr_d = in_instr;
                    skid_pc_d    = in_pc;
                    state_d      = ST_FULL;
                end else if (w_out_fire) begin
                    state_d      = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                    state_d      = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush overrides everything, including a same-cycle accept.
        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = '0;
            main_pc_d    = '0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
        end
    end

    // Ready is computed from the next state so it is a clean register output.
    assign in_ready_d = (state_d != ST_FULL);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_out_valid && !out_ready && (stall_cnt_q != c_STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + c_STALL_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = w_out_valid;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage
// Description : Directed vector table plus corner-case sequences and a
//               randomized queue-model run for pipe_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_instr, out_instr;
    logic [63:0] in_pc, out_pc;
    logic [15:0] stall_cnt;

    logic        s_iv, s_ir, s_ov, s_or, s_fl;
    logic [7:0]  s_instr_i, s_instr_o, s_pc_i, s_pc_o;
    logic [3:0]  s_stall;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pipe_stage #(.IW(32), .N(64), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage #(.IW(8), .N(8), .CW(4)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(s_iv), .in_ready(s_ir),
        .in_instr(s_instr_i), .in_pc(s_pc_i),
        .out_valid(s_ov), .out_ready(s_or),
        .out_instr(s_instr_o), .out_pc(s_pc_o),
        .flush(s_fl), .stall_cnt(s_stall)
    );

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic [15:0] e_stall;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [63:0] pc,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_main(input string nm, input logic ov, input logic ir,
                              input logic [31:0] ins, input logic [63:0] pc, input logic [15:0] st);
        check({nm, "_ov"},    64'(out_valid), 64'(ov));
        check({nm, "_ir"},    64'(in_ready),  64'(ir));
        check({nm, "_instr"}, 64'(out_instr), 64'(ins));
        check({nm, "_pc"},    out_pc,         pc);
        check({nm, "_stall"}, 64'(stall_cnt), 64'(st));
    endtask

    logic [31:0] q_instr[$];
    logic [63:0] q_pc[$];

    initial begin
        // Expected results assume each row starts from the previous row's state.
        vecs[0]  = '{1'b1, 32'h8B020020, 64'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8B020020, 64'h00, 16'd0};
        vecs[1]  = '{1'b1, 32'hF8400041, 64'h04, 1'b1, 1'b0, 1'b1, 1'b1, 32'hF8400041, 64'h04, 16'd0};
        vecs[2]  = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'hF8400041, 64'h04, 16'd0};
        vecs[3]  = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'hF8400041, 64'h04, 16'd0};
        vecs[4]  = '{1'b1, 32'h11111111, 64'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 64'h10, 16'd0};
        vecs[5]  = '{1'b1, 32'h22222222, 64'h14, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 64'h10, 16'd1};
        vecs[6]  = '{1'b1, 32'h33333333, 64'h18, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 64'h10, 16'd2};
        vecs[7]  = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22222222, 64'h14, 16'd2};
        vecs[8]  = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h22222222, 64'h14, 16'd2};
        vecs[9]  = '{1'b1, 32'h44444444, 64'h20, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44444444, 64'h20, 16'd2};
        vecs[10] = '{1'b1, 32'h55555555, 64'h24, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44444444, 64'h20, 16'd3};
        vecs[11] = '{1'b1, 32'h66666666, 64'h28, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        64'h00, 16'd4};
        vecs[12] = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        64'h00, 16'd4};
        vecs[13] = '{1'b1, 32'h77777777, 64'h2C, 1'b1, 1'b0, 1'b1, 1'b1, 32'h77777777, 64'h2C, 16'd4};
        vecs[14] = '{1'b1, 32'h88888888, 64'h30, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        64'h00, 16'd4};
        vecs[15] = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        64'h00, 16'd4};
        vecs[16] = '{1'b1, 32'h99999999, 64'h34, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        64'h00, 16'd4};
        vecs[17] = '{1'b1, 32'hAAAAAAAA, 64'h38, 1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 64'h38, 16'd4};
        vecs[18] = '{1'b0, 32'h0,        64'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 64'h38, 16'd5};
        vecs[19] = '{1'b0, 32'h0,        64'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 64'h38, 16'd5};

        reset = 1'b1;
        in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
        s_iv = 1'b0; s_instr_i = '0; s_pc_i = '0; s_or = 1'b0; s_fl = 1'b0;
        #12;
        check_main("reset", 1'b0, 1'b1, 32'h0, 64'h0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            check_main($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir,
                       vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_stall);
        end

        // Asynchronous reset between edges while FULL.
        drive(1'b1, 32'hABCD0001, 64'h40, 1'b0, 1'b0);
        drive(1'b1, 32'hABCD0002, 64'h44, 1'b0, 1'b0);
        check_main("fill", 1'b1, 1'b0, 32'hABCD0001, 64'h40, 16'd6);
        #2;
        reset = 1'b1;
        #1;
        check_main("async_rst", 1'b0, 1'b1, 32'h0, 64'h0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 32'hABCD0003, 64'h48, 1'b1, 1'b0);
        check_main("post_rst", 1'b1, 1'b1, 32'hABCD0003, 64'h48, 16'd0);
        drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        check_main("post_rst_drain", 1'b0, 1'b1, 32'hABCD0003, 64'h48, 16'd0);

        // Saturation on the CW=4 instance.
        @(negedge clk);
        s_iv = 1'b1; s_instr_i = 8'h5A; s_pc_i = 8'h08; s_or = 1'b0;
        @(posedge clk); #1;
        check("sat_load_ov", 64'(s_ov), 64'd1);
        @(negedge clk);
        s_iv = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk); #1;
            check($sformatf("sat_cnt%0d", k), 64'(s_stall), 64'((k > 15) ? 15 : k));
        end
        check("sat_hold_instr", 64'(s_instr_o), 64'h5A);

        // Randomized run against a queue reference.
        begin
            logic [63:0] seq_pc;
            int          st_exp;
            seq_pc = 64'h1000;
            st_exp = 0;
            @(negedge clk);
            reset = 1'b1;
            #1;
            reset = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                in_valid  = 1'($urandom_range(0, 1));
                in_instr  = $urandom;
                in_pc     = seq_pc;
                out_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 99) < 5);
                #1;
                check("rnd_ov", 64'(out_valid), 64'(q_instr.size() != 0));
                check("rnd_ir", 64'(in_ready),  64'(q_instr.size() < 2));
                if (out_valid && out_ready && q_instr.size() > 0) begin
                    check("rnd_instr", 64'(out_instr), 64'(q_instr[0]));
                    check("rnd_pc",    out_pc,         q_pc[0]);
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
                if (out_valid && !out_ready) st_exp++;
                if (flush) begin
                    q_instr.delete();
                    q_pc.delete();
                end else if (in_valid && in_ready) begin
                    q_instr.push_back(in_instr);
                    q_pc.push_back(in_pc);
                    seq_pc = seq_pc + 64'd4;
                end
                @(posedge clk);
            end
            #1;
            check("rnd_stall", 64'(stall_cnt), 64'(st_exp));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
